// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
// Imported by pipeline_ctrl and hazard_detect.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RUN,
      ST_MEMWAIT,
      ST_DRAIN,
      ST_HALTED
   } state_e;

   localparam int unsigned DRAIN_CYCLES = 3;
   localparam int unsigned MEM_TIMEOUT  = 255;
   localparam int unsigned STALL_CNT_W  = 16;

   localparam int unsigned WAIT_CNT_W   = 8;
   localparam int unsigned DRAIN_CNT_W  = 2;
   localparam int unsigned REG_ADDR_W   = 5;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection between the IDEX load and the IFID sources.
// Purely combinational.
module hazard_detect
   import pipe_ctrl_pkg::*;
(
   input  logic                  mem_read_i,
   input  logic [REG_ADDR_W-1:0] rd_i,
   input  logic [REG_ADDR_W-1:0] rs1_i,
   input  logic [REG_ADDR_W-1:0] rs2_i,
   output logic                  hazard_o
);

   // x0 never carries a dependency
   assign hazard_o = mem_read_i
                   && (rd_i != '0)
                   && ((rd_i == rs1_i) || (rd_i == rs2_i));

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline control: stall, flush, freeze and halt sequencing.
// Control outputs are Mealy (state plus current inputs).
module pipeline_ctrl
   import pipe_ctrl_pkg::*;
(
   input  logic                   clkIn,
   input  logic                   resetIn,
   input  logic                   idexMemReadIn,
   input  logic [REG_ADDR_W-1:0]  idexRdIn,
   input  logic [REG_ADDR_W-1:0]  ifidRs1In,
   input  logic [REG_ADDR_W-1:0]  ifidRs2In,
   input  logic                   branchTakenIn,
   input  logic                   memReqIn,
   input  logic                   memReadyIn,
   input  logic                   haltIn,
   input  logic                   resumeIn,
   output logic                   pcWriteEnOut,
   output logic                   ifidWriteEnOut,
   output logic                   ifidFlushOut,
   output logic                   idexFlushOut,
   output logic                   freezeOut,
   output logic                   haltedOut,
   output logic                   memTimeoutOut,
   output logic [STALL_CNT_W-1:0] stallCntOut
);

   localparam logic [WAIT_CNT_W-1:0] WAIT_MAX =
      WAIT_CNT_W'(MEM_TIMEOUT);
   localparam logic [WAIT_CNT_W-1:0] WAIT_PRE =
      WAIT_CNT_W'(MEM_TIMEOUT - 1);
   localparam logic [DRAIN_CNT_W-1:0] DRAIN_LD =
      DRAIN_CNT_W'(DRAIN_CYCLES);

   state_e                   state_q, state_d;
   logic [DRAIN_CNT_W-1:0]   drain_q, drain_d;
   logic [WAIT_CNT_W-1:0]    wait_q, wait_d;
   logic                     tmo_q, tmo_d;
   logic [STALL_CNT_W-1:0]   stall_q, stall_d;

   logic hazard;
   logic mem_wait;
   logic run_dec;
   logic tmo_hit;
   logic bubble;
   logic pc_we, ifid_we, ifid_fl, idex_fl, frz;

   hazard_detect u_hazard (
      .mem_read_i (idexMemReadIn),
      .rd_i       (idexRdIn),
      .rs1_i      (ifidRs1In),
      .rs2_i      (ifidRs2In),
      .hazard_o   (hazard)
   );

   assign mem_wait = memReqIn & ~memReadyIn;

   always_comb begin
      state_d = state_q;
      drain_d = drain_q;
      wait_d  = wait_q;
      run_dec = 1'b0;
      tmo_hit = 1'b0;
      bubble  = 1'b0;
      pc_we   = 1'b0;
      ifid_we = 1'b0;
      ifid_fl = 1'b0;
      idex_fl = 1'b0;
      frz     = 1'b0;

      unique case (state_q)
         ST_RUN: run_dec = 1'b1;
         ST_MEMWAIT: begin
            if (!memReadyIn) begin
               frz = 1'b1;
               if (wait_q != WAIT_MAX) wait_d = wait_q + 1'b1;
               if (wait_q >= WAIT_PRE) tmo_hit = 1'b1;
            end else begin
               run_dec = 1'b1;
            end
         end
         ST_DRAIN: begin
            if (mem_wait) begin
               frz = 1'b1;
            end else begin
               idex_fl = 1'b1;
               bubble  = hazard;
               drain_d = drain_q - 1'b1;
               if (drain_q == DRAIN_CNT_W'(1)) state_d = ST_HALTED;
            end
         end
         ST_HALTED: begin
            if (resumeIn) state_d = ST_RUN;
         end
      endcase

      // Released MEMWAIT decodes exactly like RUN
      if (run_dec) begin
         state_d = ST_RUN;
         if (mem_wait) begin
            frz     = 1'b1;
            state_d = ST_MEMWAIT;
            wait_d  = WAIT_CNT_W'(1);
         end else if (branchTakenIn) begin
            pc_we   = 1'b1;
            ifid_we = 1'b1;
            ifid_fl = 1'b1;
            idex_fl = 1'b1;
         end else if (hazard) begin
            idex_fl = 1'b1;
            bubble  = 1'b1;
         end else if (haltIn) begin
            idex_fl = 1'b1;
            drain_d = DRAIN_LD;
            state_d = ST_DRAIN;
         end else begin
            pc_we   = 1'b1;
            ifid_we = 1'b1;
         end
      end

      tmo_d   = tmo_q | tmo_hit;
      stall_d = (frz | bubble) ? stall_q + 1'b1 : stall_q;
   end

   always_ff @(posedge clkIn or negedge resetIn) begin
      if (!resetIn) begin
         state_q <= ST_RUN;
         drain_q <= '0;
         wait_q  <= '0;
         tmo_q   <= 1'b0;
         stall_q <= '0;
      end else begin
         state_q <= state_d;
         drain_q <= drain_d;
         wait_q  <= wait_d;
         tmo_q   <= tmo_d;
         stall_q <= stall_d;
      end
   end

   // Reset forces a bubble into both front-end registers
   assign pcWriteEnOut   = resetIn & pc_we;
   assign ifidWriteEnOut = resetIn & ifid_we;
   assign ifidFlushOut   = ~resetIn | ifid_fl;
   assign idexFlushOut   = ~resetIn | idex_fl;
   assign freezeOut      = resetIn & frz;
   assign haltedOut      = (state_q == ST_HALTED);
   assign memTimeoutOut  = tmo_q | (resetIn & tmo_hit);
   assign stallCntOut    = stall_q;

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 clkIn  in  1  single clock; all state updates on rising edge.
REQ-002 resetIn  in  1  asynchronous, active-low reset.
REQ-003 idexMemReadIn  in  1  instruction in IDEX is a load.
REQ-004 idexRdIn  in  5  destination register of the IDEX instruction.
REQ-005 ifidRs1In, ifidRs2In  in  5 each  source registers of the IFID instruction.
REQ-006 branchTakenIn  in  1  EX resolved a taken branch or jump this cycle.
REQ-007 memReqIn  in  1  EXMA instruction accesses data memory this cycle.
REQ-008 memReadyIn  in  1  data memory completes the access this cycle.
REQ-009 haltIn  in  1  IFID instruction is a halt (ecall).
REQ-010 resumeIn  in  1  leave the halted state.
REQ-011 pcWriteEnOut  out  1  PC loads its next value.
REQ-012 ifidWriteEnOut  out  1  IFID loads; 0 holds IFID.
REQ-013 ifidFlushOut  out  1  IFID loads zeros.
REQ-014 idexFlushOut  out  1  IDEX loads zeros (bubble).
REQ-015 freezeOut  out  1  PC, IFID, IDEX, EXMA, MAWB all hold; has priority over every other control output.
REQ-016 haltedOut  out  1  pipeline drained and stopped.
REQ-017 memTimeoutOut  out  1  sticky: a memory wait reached MEM_TIMEOUT cycles.
REQ-018 stallCntOut  out  16  wrapping count of stall cycles.

Function
REQ-019 The FSM SHALL have states RUN, MEMWAIT, DRAIN, HALTED; the control outputs SHALL be Mealy, i.e. combinational from state and inputs.
REQ-020 RUN, event priority: memory wait > branch > load-use > halt > none.
REQ-021 RUN, memReqIn=1 and memReadyIn=0: freezeOut=1 this cycle; next state MEMWAIT.
REQ-022 RUN, branchTakenIn=1: pcWriteEnOut=1, ifidFlushOut=1, idexFlushOut=1; haltIn and load-use are ignored.
REQ-023 RUN, load-use (idexMemReadIn=1, idexRdIn!=0, idexRdIn equals ifidRs1In or ifidRs2In): pcWriteEnOut=0, ifidWriteEnOut=0, idexFlushOut=1 for exactly that cycle.
REQ-024 RUN, haltIn=1 with no higher event: pcWriteEnOut=0, ifidWriteEnOut=0, idexFlushOut=1; load drain counter with DRAIN_CYCLES=3; next state DRAIN.
REQ-025 RUN, no event: pcWriteEnOut=1, ifidWriteEnOut=1, all flushes and freeze 0.
REQ-026 MEMWAIT: freezeOut=1 while memReadyIn=0; the cycle memReadyIn=1: freezeOut=0, normal RUN decode of the other inputs applies, next state RUN.
REQ-027 MEMWAIT: branchTakenIn and load-use SHALL be ignored while frozen; the held instructions re-present them after release.
REQ-028 MEMWAIT: wait counter (8 bits) increments each frozen cycle; on reaching MEM_TIMEOUT=255 it SHALL set memTimeoutOut and saturate; the state remains MEMWAIT.
REQ-029 DRAIN: pcWriteEnOut=0, ifidWriteEnOut=0, idexFlushOut=1; counter decrements each unfrozen cycle; at 0 next state is HALTED.
REQ-030 DRAIN with a memory wait: freezeOut=1, counter paused, the state remains DRAIN; branchTakenIn is ignored.
REQ-031 HALTED: pcWriteEnOut=0, ifidWriteEnOut=0, haltedOut=1; resumeIn=1 SHALL give next state RUN and pcWriteEnOut=1 the following cycle.
REQ-032 stallCntOut SHALL increment by 1 on every cycle with freezeOut=1 or a load-use bubble (RUN or DRAIN), wrapping 0xFFFF to 0x0000.
REQ-033 The wait counter SHALL clear on every entry to MEMWAIT; memTimeoutOut SHALL clear only on reset.

Reset
REQ-034 resetIn low SHALL immediately force: state RUN, counters 0, memTimeoutOut=0, haltedOut=0, pcWriteEnOut=0, ifidWriteEnOut=0, ifidFlushOut=1, idexFlushOut=1, freezeOut=0.
REQ-035 Reset asserted mid-MEMWAIT or mid-DRAIN SHALL abort the operation with no residual state; first cycle after release behaves as RUN.

Structure
REQ-036 Package pipe_ctrl_pkg SHALL hold the state enum, DRAIN_CYCLES=3, MEM_TIMEOUT=255, and STALL_CNT_W=16.
REQ-037 Load-use comparison SHALL be a combinational sub-module hazard_detect.

Verification
REQ-038 ld x5 in IDEX, add x6,x5,x1 in IFID -> one cycle pcWriteEnOut=0, idexFlushOut=1; stallCntOut +1.
REQ-039 Load with idexRdIn=0 and ifidRs1In=0 -> no stall.
REQ-040 memReqIn=1, memReadyIn=0 for 4 cycles, then 1 -> freezeOut high 4 cycles, low on the ready cycle; stallCntOut +4.
REQ-041 branchTakenIn=1 together with load-use and haltIn -> flushes only, pcWriteEnOut=1, state RUN.
REQ-042 haltIn with one 2-cycle memory wait during DRAIN -> haltedOut rises 5 cycles after the halt cycle; resumeIn -> RUN.
REQ-043 memReadyIn held 0 for 300 cycles, then resetIn pulsed -> memTimeoutOut=1 from frozen cycle 255; after reset all outputs at reset values.
